snn_spike_decoder: RTL and testbench
====================================

# snn_spike_decoder

Readout stage between the SNN output layer and the AXI4-Lite output register. It counts AER spike events from the N_OUT output neurons over one inference window and runs a serial argmax scan once the window closes. It then presents the winning class on INFERED_DIGIT and raises COPROCESSOR_RDY. Both outputs are held stable for the processor to sample through the output register.

## Interface
- N_OUT, 10, number of output neurons/classes (2..255)
- CNT_WIDTH, 8, width of each per-class spike counter
- SPK_ADDR_WIDTH, 8, width of the spike event address
- ACLK  in  1  clock
- ARESETN  in  1  reset; asynchronous, active-low
- START  in  1  single-cycle pulse: new inference window begins (image loaded)
- WINDOW_END  in  1  single-cycle pulse: last timestep of the window finished
- SPIKE_VALID  in  1  output-layer spike event valid this cycle
- SPIKE_ADDR  in  SPK_ADDR_WIDTH  index of the spiking output neuron
- BUSY  out  1  high in COUNT or SCAN
- COPROCESSOR_RDY  out  1  result valid; high in DONE only
- INFERED_DIGIT  out  8  winning class index, or 8'hFF if no output spike occurred

## Operation
- States: IDLE, COUNT, SCAN, DONE. All outputs are registered.
- Reset (async, ARESETN low): state is IDLE, all counters are 0, and the scan index is 0. Outputs are BUSY=0, COPROCESSOR_RDY=0 and INFERED_DIGIT=8'hFF.
- IDLE, START=1: clear all counters and go to COUNT.
- COUNT behaviour:
  - SPIKE_VALID=1 with SPIKE_ADDR<N_OUT increments cnt[SPIKE_ADDR].
  - A counter saturates at 2^CNT_WIDTH-1 and does not wrap.
  - Addresses >=N_OUT are silently dropped.
  - WINDOW_END=1: go to SCAN and init idx=0, best_cnt=0, best_idx=8'hFF. A spike in the same cycle as WINDOW_END is counted.
- SCAN: one counter is examined per cycle.
  - If cnt[idx] > best_cnt (strict), update best_cnt=cnt[idx] and best_idx=idx.
  - idx increments each cycle.
  - After idx=N_OUT-1 is processed, go to DONE and register INFERED_DIGIT=final best_idx and COPROCESSOR_RDY=1.
  - The strict compare means ties resolve to the lowest index. All-zero counts yield 8'hFF.
- DONE: outputs are held until the next START.
- START has priority in every state, including COUNT with a simultaneous WINDOW_END:
  - Counters clear, the state goes to COUNT and COPROCESSOR_RDY drops on that edge.
  - INFERED_DIGIT keeps its previous value; it is stale whenever COPROCESSOR_RDY=0.
- WINDOW_END outside COUNT is ignored. SPIKE_VALID outside COUNT is ignored, including the START cycle itself.
- SPIKE_ADDR is ignored when SPIKE_VALID=0.

## Timing
- START sampled at edge t: BUSY=1 and COPROCESSOR_RDY=0 after edge t. Spikes are counted from edge t+1.
- WINDOW_END sampled at edge e: SCAN occupies edges e+1..e+N_OUT. COPROCESSOR_RDY=1, BUSY=0 and INFERED_DIGIT are valid after edge e+N_OUT (latency N_OUT cycles).
- Counter increment is single-cycle; back-to-back spikes to the same address every cycle must all count.
- Async reset asserted mid-COUNT or mid-SCAN takes effect immediately, with no clock needed. Reset release is synchronous to ACLK.

## Test plan
- Reset then idle: assert ARESETN=0 asynchronously -> BUSY=0, COPROCESSOR_RDY=0, INFERED_DIGIT=8'hFF with no clock edge required.
- Basic inference (N_OUT=10): START; spikes addr3 x5, addr7 x2; WINDOW_END -> COPROCESSOR_RDY=1 exactly 10 cycles after WINDOW_END, with INFERED_DIGIT=3.
- Tie and zero case:
  - Spikes addr6 x4 and addr2 x4 -> INFERED_DIGIT=2.
  - Next window with no spikes -> INFERED_DIGIT=8'hFF.
- Saturation and filtering (CNT_WIDTH=8):
  - 300 consecutive-cycle spikes to addr1, 260 to addr4, 10 to addr 12 (ignored) -> both counters saturate at 255, and INFERED_DIGIT=1 via the tie rule.
  - A spike on the WINDOW_END cycle is counted: addr5 x3 and addr8 x2 plus one more addr8 on the WINDOW_END cycle -> INFERED_DIGIT=5 (3 vs 3 tie).
- Restart priority:
  - START during SCAN -> BUSY stays 1, COPROCESSOR_RDY never pulses, and counters restart from 0.
  - START+WINDOW_END in the same cycle -> stays in COUNT.
  - START in DONE -> COPROCESSOR_RDY=0 the next cycle, with INFERED_DIGIT still holding the previous value.
- Reset mid-SCAN: pulse ARESETN low during SCAN -> outputs return to reset values immediately. A later START/WINDOW_END with addr9 x1 -> INFERED_DIGIT=9.

Source files
------------

// File: rtl/snn_spike_decoder_if.sv
// Spike-readout bus between the SNN output layer / control FSM and the decoder.
// Control pulses and spike events flow in; status and the winning class flow out.
interface snn_spike_decoder_if #(
    parameter int SPK_ADDR_WIDTH = 8
);
    logic                      START;
    logic                      WINDOW_END;
    logic                      SPIKE_VALID;
    logic [SPK_ADDR_WIDTH-1:0] SPIKE_ADDR;
    logic                      BUSY;
    logic                      COPROCESSOR_RDY;
    logic [7:0]                INFERED_DIGIT;

    modport master (
        output START, WINDOW_END, SPIKE_VALID, SPIKE_ADDR,
        input  BUSY, COPROCESSOR_RDY, INFERED_DIGIT
    );

    modport slave (
        input  START, WINDOW_END, SPIKE_VALID, SPIKE_ADDR,
        output BUSY, COPROCESSOR_RDY, INFERED_DIGIT
    );
endinterface

// File: rtl/snn_spike_decoder.sv
// Counts output-layer spikes per class over a window, then serially scans for the argmax.
// Result latency is N_OUT cycles after WINDOW_END; no backpressure, START always restarts.
module snn_spike_decoder #(
    parameter int N_OUT          = 10,
    parameter int CNT_WIDTH      = 8,
    parameter int SPK_ADDR_WIDTH = 8
) (
    input  logic                  ACLK,
    input  logic                  ARESETN,
    snn_spike_decoder_if.slave    bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_COUNT = 2'd1,
        S_SCAN  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam int                        IDX_W    = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam logic [CNT_WIDTH-1:0]      CNT_MAX  = '1;
    localparam logic [7:0]                IDX_LAST = 8'(N_OUT - 1);
    localparam logic [SPK_ADDR_WIDTH-1:0] ADDR_LIM = SPK_ADDR_WIDTH'(N_OUT);

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q [N_OUT];
    logic [CNT_WIDTH-1:0] cnt_d [N_OUT];
    logic [7:0]           idx_q, idx_d;
    logic [CNT_WIDTH-1:0] best_cnt_q, best_cnt_d;
    logic [7:0]           best_idx_q, best_idx_d;
    logic                 busy_q, busy_d;
    logic                 rdy_q, rdy_d;
    logic [7:0]           digit_q, digit_d;

    logic                 spike_hit;
    logic [IDX_W-1:0]     spike_idx;
    logic [CNT_WIDTH-1:0] scan_cnt;
    logic                 scan_gt;
    logic                 scan_last;
    logic [7:0]           scan_best_idx;

    // Out-of-range addresses never reach the counter array.
    assign spike_hit = (state_q == S_COUNT) && bus.SPIKE_VALID && (bus.SPIKE_ADDR < ADDR_LIM);
    assign spike_idx = bus.SPIKE_ADDR[IDX_W-1:0];

    // Strict greater-than keeps the lowest index on ties; all-zero leaves 8'hFF.
    assign scan_cnt      = cnt_q[idx_q[IDX_W-1:0]];
    assign scan_gt       = scan_cnt > best_cnt_q;
    assign scan_last     = (idx_q == IDX_LAST);
    assign scan_best_idx = scan_gt ? idx_q : best_idx_q;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (bus.START) begin
            state_d = S_COUNT;
        end else begin
            case (state_q)
                S_COUNT: if (bus.WINDOW_END) state_d = S_SCAN;
                S_SCAN:  if (scan_last)      state_d = S_DONE;
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        busy_d  = (state_d == S_COUNT) || (state_d == S_SCAN);
        rdy_d   = (state_d == S_DONE);
        digit_d = digit_q;
        if (!bus.START && (state_q == S_SCAN) && scan_last) begin
            digit_d = scan_best_idx;
        end
    end

    always_comb begin
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        best_cnt_d = best_cnt_q;
        best_idx_d = best_idx_q;
        if (bus.START) begin
            for (int i = 0; i < N_OUT; i++) begin
                cnt_d[i] = '0;
            end
        end else begin
            case (state_q)
                S_COUNT: begin
                    if (spike_hit && (cnt_q[spike_idx] != CNT_MAX)) begin
                        cnt_d[spike_idx] = cnt_q[spike_idx] + 1'b1;
                    end
                    if (bus.WINDOW_END) begin
                        idx_d      = '0;
                        best_cnt_d = '0;
                        best_idx_d = 8'hFF;
                    end
                end
                S_SCAN: begin
                    if (scan_gt) begin
                        best_cnt_d = scan_cnt;
                        best_idx_d = idx_q;
                    end
                    idx_d = idx_q + 8'd1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            for (int i = 0; i < N_OUT; i++) begin
                cnt_q[i] <= '0;
            end
            idx_q      <= '0;
            best_cnt_q <= '0;
            best_idx_q <= 8'hFF;
            busy_q     <= 1'b0;
            rdy_q      <= 1'b0;
            digit_q    <= 8'hFF;
        end else begin
            for (int i = 0; i < N_OUT; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            idx_q      <= idx_d;
            best_cnt_q <= best_cnt_d;
            best_idx_q <= best_idx_d;
            busy_q     <= busy_d;
            rdy_q      <= rdy_d;
            digit_q    <= digit_d;
        end
    end

    assign bus.BUSY            = busy_q;
    assign bus.COPROCESSOR_RDY = rdy_q;
    assign bus.INFERED_DIGIT   = digit_q;

endmodule

// File: tb/tb_snn_spike_decoder.sv
// Scenario bench for the spike decoder: a reference counter/argmax model feeds a
// scoreboard of expected digits, popped when the decoder reports a result.
module tb_snn_spike_decoder;

    localparam int N_OUT = 10;
    localparam int CMAX  = 255;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    snn_spike_decoder_if #(.SPK_ADDR_WIDTH(8)) bus ();

    snn_spike_decoder #(
        .N_OUT(N_OUT),
        .CNT_WIDTH(8),
        .SPK_ADDR_WIDTH(8)
    ) dut (
        .ACLK(clk),
        .ARESETN(rst_n),
        .bus(bus.slave)
    );

    int         checks = 0;
    int         errors = 0;
    int         m_cnt [N_OUT];
    logic [7:0] sb_q [$];
    logic [7:0] last_digit = 8'hFF;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < N_OUT; i++) m_cnt[i] = 0;
    endtask

    task automatic model_count(input int addr);
        if (addr < N_OUT && m_cnt[addr] < CMAX) m_cnt[addr]++;
    endtask

    function automatic logic [7:0] model_argmax();
        int         best = 0;
        logic [7:0] bi   = 8'hFF;
        for (int i = 0; i < N_OUT; i++) begin
            if (m_cnt[i] > best) begin
                best = m_cnt[i];
                bi   = 8'(i);
            end
        end
        return bi;
    endfunction

    task automatic do_start(input logic spk, input logic [7:0] addr);
        bus.START       = 1'b1;
        bus.SPIKE_VALID = spk;
        bus.SPIKE_ADDR  = addr;
        model_clear();
        tick();
        bus.START       = 1'b0;
        bus.SPIKE_VALID = 1'b0;
    endtask

    task automatic spikes(input logic [7:0] addr, input int n);
        for (int i = 0; i < n; i++) begin
            bus.SPIKE_VALID = 1'b1;
            bus.SPIKE_ADDR  = addr;
            model_count(int'(addr));
            tick();
        end
        bus.SPIKE_VALID = 1'b0;
    endtask

    task automatic window_end(input logic spk, input logic [7:0] addr);
        bus.WINDOW_END  = 1'b1;
        bus.SPIKE_VALID = spk;
        bus.SPIKE_ADDR  = addr;
        if (spk) model_count(int'(addr));
        sb_q.push_back(model_argmax());
        tick();
        bus.WINDOW_END  = 1'b0;
        bus.SPIKE_VALID = 1'b0;
    endtask

    // Cycles after the WINDOW_END edge until RDY rises; -1 if the budget expires.
    task automatic collect(output int lat, output logic [7:0] dig);
        lat = -1;
        for (int k = 1; k <= N_OUT + 8; k++) begin
            tick();
            if (bus.COPROCESSOR_RDY === 1'b1) begin
                lat = k;
                break;
            end
        end
        dig = bus.INFERED_DIGIT;
    endtask

    task automatic test_reset();
        #3 rst_n = 1'b0;
        #1;
        checks++; if (bus.BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.BUSY); end
        checks++; if (bus.COPROCESSOR_RDY !== 1'b0) begin errors++; $display("FAIL reset_rdy: got %b want 0", bus.COPROCESSOR_RDY); end
        checks++; if (bus.INFERED_DIGIT !== 8'hFF) begin errors++; $display("FAIL reset_digit: got %h want ff", bus.INFERED_DIGIT); end
        tick(); tick();
        rst_n = 1'b1;
        tick(); tick();
        checks++; if (bus.BUSY !== 1'b0 || bus.COPROCESSOR_RDY !== 1'b0) begin
            errors++; $display("FAIL idle_after_reset: busy=%b rdy=%b want 0 0", bus.BUSY, bus.COPROCESSOR_RDY);
        end
    endtask

    task automatic test_basic();
        int lat; logic [7:0] dig, exp;
        do_start(1'b0, 8'd0);
        checks++; if (bus.BUSY !== 1'b1 || bus.COPROCESSOR_RDY !== 1'b0) begin
            errors++; $display("FAIL basic_start: busy=%b rdy=%b want 1 0", bus.BUSY, bus.COPROCESSOR_RDY);
        end
        spikes(8'd3, 5);
        spikes(8'd7, 2);
        window_end(1'b0, 8'd0);
        collect(lat, dig);
        exp = sb_q.pop_front(); last_digit = exp;
        checks++; if (lat != N_OUT) begin errors++; $display("FAIL basic_latency: got %0d want %0d", lat, N_OUT); end
        checks++; if (dig !== exp) begin errors++; $display("FAIL basic_digit: got %0d want %0d", dig, exp); end
        checks++; if (bus.BUSY !== 1'b0) begin errors++; $display("FAIL basic_busy_done: got %b want 0", bus.BUSY); end
        for (int i = 0; i < 5; i++) tick();
        checks++; if (bus.COPROCESSOR_RDY !== 1'b1 || bus.INFERED_DIGIT !== exp) begin
            errors++; $display("FAIL basic_hold: rdy=%b digit=%0d want 1 %0d", bus.COPROCESSOR_RDY, bus.INFERED_DIGIT, exp);
        end
    endtask

    task automatic test_tie_zero();
        int lat; logic [7:0] dig, exp;
        do_start(1'b0, 8'd0);
        spikes(8'd6, 4);
        spikes(8'd2, 4);
        window_end(1'b0, 8'd0);
        collect(lat, dig);
        exp = sb_q.pop_front(); last_digit = exp;
        checks++; if (lat != N_OUT || dig !== exp) begin
            errors++; $display("FAIL tie_digit: lat=%0d digit=%0d want %0d %0d", lat, dig, N_OUT, exp);
        end
        do_start(1'b0, 8'd0);
        for (int i = 0; i < 4; i++) tick();
        window_end(1'b0, 8'd0);
        collect(lat, dig);
        exp = sb_q.pop_front(); last_digit = exp;
        checks++; if (lat != N_OUT || dig !== exp) begin
            errors++; $display("FAIL zero_digit: lat=%0d digit=%h want %0d %h", lat, dig, N_OUT, exp);
        end
    endtask

    task automatic test_saturation();
        int lat; logic [7:0] dig, exp;
        do_start(1'b0, 8'd0);
        spikes(8'd1, 300);
        spikes(8'd4, 260);
        spikes(8'd12, 10);
        window_end(1'b0, 8'd0);
        collect(lat, dig);
        exp = sb_q.pop_front(); last_digit = exp;
        checks++; if (lat != N_OUT || dig !== exp) begin
            errors++; $display("FAIL saturation_digit: lat=%0d digit=%0d want %0d %0d", lat, dig, N_OUT, exp);
        end
    endtask

    task automatic test_window_end_spike();
        int lat; logic [7:0] dig, exp;
        do_start(1'b0, 8'd0);
        spikes(8'd5, 3);
        spikes(8'd8, 2);
        window_end(1'b1, 8'd8);
        collect(lat, dig);
        exp = sb_q.pop_front(); last_digit = exp;
        checks++; if (lat != N_OUT || dig !== exp) begin
            errors++; $display("FAIL we_spike_digit: lat=%0d digit=%0d want %0d %0d", lat, dig, N_OUT, exp);
        end
    endtask

    task automatic test_start_in_scan();
        int lat; logic [7:0] dig, exp;
        logic rdy_seen = 1'b0, busy_drop = 1'b0;
        do_start(1'b0, 8'd0);
        spikes(8'd0, 3);
        window_end(1'b0, 8'd0);
        void'(sb_q.pop_back());
        tick(); tick(); tick();
        do_start(1'b0, 8'd0);
        for (int i = 0; i < N_OUT + 3; i++) begin
            if (bus.COPROCESSOR_RDY !== 1'b0) rdy_seen = 1'b1;
            if (bus.BUSY !== 1'b1) busy_drop = 1'b1;
            tick();
        end
        checks++; if (rdy_seen || busy_drop) begin
            errors++; $display("FAIL scan_restart_status: rdy_seen=%b busy_drop=%b want 0 0", rdy_seen, busy_drop);
        end
        spikes(8'd4, 1);
        window_end(1'b0, 8'd0);
        collect(lat, dig);
        exp = sb_q.pop_front(); last_digit = exp;
        checks++; if (lat != N_OUT || dig !== exp) begin
            errors++; $display("FAIL scan_restart_digit: lat=%0d digit=%0d want %0d %0d", lat, dig, N_OUT, exp);
        end
    endtask

    task automatic test_start_with_window_end();
        int lat; logic [7:0] dig, exp;
        logic rdy_seen = 1'b0;
        do_start(1'b0, 8'd0);
        spikes(8'd2, 2);
        bus.START      = 1'b1;
        bus.WINDOW_END = 1'b1;
        model_clear();
        tick();
        bus.START      = 1'b0;
        bus.WINDOW_END = 1'b0;
        for (int i = 0; i < N_OUT + 3; i++) begin
            if (bus.COPROCESSOR_RDY !== 1'b0 || bus.BUSY !== 1'b1) rdy_seen = 1'b1;
            tick();
        end
        checks++; if (rdy_seen) begin errors++; $display("FAIL start_we_stays_count: left COUNT, want busy=1 rdy=0 throughout"); end
        spikes(8'd6, 1);
        window_end(1'b0, 8'd0);
        collect(lat, dig);
        exp = sb_q.pop_front(); last_digit = exp;
        checks++; if (lat != N_OUT || dig !== exp) begin
            errors++; $display("FAIL start_we_digit: lat=%0d digit=%0d want %0d %0d", lat, dig, N_OUT, exp);
        end
    endtask

    task automatic test_start_in_done();
        int lat; logic [7:0] dig, exp;
        do_start(1'b1, 8'd0);
        checks++; if (bus.COPROCESSOR_RDY !== 1'b0 || bus.BUSY !== 1'b1) begin
            errors++; $display("FAIL done_restart_status: rdy=%b busy=%b want 0 1", bus.COPROCESSOR_RDY, bus.BUSY);
        end
        checks++; if (bus.INFERED_DIGIT !== last_digit) begin
            errors++; $display("FAIL done_restart_stale: got %0d want %0d", bus.INFERED_DIGIT, last_digit);
        end
        window_end(1'b0, 8'd0);
        collect(lat, dig);
        exp = sb_q.pop_front(); last_digit = exp;
        checks++; if (lat != N_OUT || dig !== exp) begin
            errors++; $display("FAIL start_cycle_spike_ignored: lat=%0d digit=%h want %0d %h", lat, dig, N_OUT, exp);
        end
    endtask

    task automatic test_reset_mid_scan();
        int lat; logic [7:0] dig, exp;
        do_start(1'b0, 8'd0);
        spikes(8'd3, 1);
        window_end(1'b0, 8'd0);
        void'(sb_q.pop_back());
        tick(); tick(); tick(); tick();
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.BUSY !== 1'b0 || bus.COPROCESSOR_RDY !== 1'b0 || bus.INFERED_DIGIT !== 8'hFF) begin
            errors++; $display("FAIL scan_reset: busy=%b rdy=%b digit=%h want 0 0 ff", bus.BUSY, bus.COPROCESSOR_RDY, bus.INFERED_DIGIT);
        end
        tick();
        rst_n = 1'b1;
        tick();
        do_start(1'b0, 8'd0);
        spikes(8'd9, 1);
        window_end(1'b0, 8'd0);
        collect(lat, dig);
        exp = sb_q.pop_front(); last_digit = exp;
        checks++; if (lat != N_OUT || dig !== exp) begin
            errors++; $display("FAIL post_reset_digit: lat=%0d digit=%0d want %0d %0d", lat, dig, N_OUT, exp);
        end
    endtask

    initial begin
        bus.START       = 1'b0;
        bus.WINDOW_END  = 1'b0;
        bus.SPIKE_VALID = 1'b0;
        bus.SPIKE_ADDR  = '0;
        model_clear();
        test_reset();
        test_basic();
        test_tie_zero();
        test_saturation();
        test_window_end_spike();
        test_start_in_scan();
        test_start_with_window_end();
        test_start_in_done();
        test_reset_mid_scan();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
